// File: rtl/lsu_pkg.sv
// Shared definitions for the load/store unit: funct3 encodings, FSM states,
// error causes and the access-legality helpers.
package lsu_pkg;

    localparam logic [2:0] LB  = 3'b000;
    localparam logic [2:0] LH  = 3'b001;
    localparam logic [2:0] LW  = 3'b010;
    localparam logic [2:0] LBU = 3'b100;
    localparam logic [2:0] LHU = 3'b101;
    localparam logic [2:0] SB  = 3'b000;
    localparam logic [2:0] SH  = 3'b001;
    localparam logic [2:0] SW  = 3'b010;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        RESP = 2'd2
    } lsu_state_e;

    localparam logic [1:0] ERR_NONE     = 2'b00;
    localparam logic [1:0] ERR_MISALIGN = 2'b01;
    localparam logic [1:0] ERR_ILLEGAL  = 2'b10;
    localparam logic [1:0] ERR_TIMEOUT  = 2'b11;

    function automatic logic f3_legal(input logic we, input logic [2:0] f3);
        logic ok;
        if (we) ok = (f3 == SB) || (f3 == SH) || (f3 == SW);
        else    ok = (f3 == LB) || (f3 == LH) || (f3 == LW) || (f3 == LBU) || (f3 == LHU);
        return ok;
    endfunction

    // funct3[1:0] encodes the access size for both loads and stores
    function automatic logic f3_misaligned(input logic [2:0] f3, input logic [1:0] off);
        logic bad;
        bad = 1'b0;
        case (f3[1:0])
            2'b01:   bad = off[0];
            2'b10:   bad = (off != 2'b00);
            default: bad = 1'b0;
        endcase
        return bad;
    endfunction

endpackage

// File: rtl/load_store_unit_if.sv
// Data-memory bus between the load/store unit (master) and memory (slave).
interface load_store_unit_if #(parameter int XLEN = 32);

    logic            mem_req;
    logic            mem_we;
    logic [XLEN-1:0] mem_addr;
    logic [3:0]      mem_be;
    logic [XLEN-1:0] mem_wdata;
    logic            mem_ready;
    logic [XLEN-1:0] mem_rdata;

    modport master (
        output mem_req, mem_we, mem_addr, mem_be, mem_wdata,
        input  mem_ready, mem_rdata
    );

    modport slave (
        input  mem_req, mem_we, mem_addr, mem_be, mem_wdata,
        output mem_ready, mem_rdata
    );

endinterface

// File: rtl/lsu_load_align.sv
// Combinational load-data extraction: shifts the addressed byte/halfword
// down to bit 0 and sign- or zero-extends it according to funct3.
module lsu_load_align
    import lsu_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic [2:0]      funct3_i,
    input  logic [1:0]      off_i,
    input  logic [XLEN-1:0] rdata_i,
    output logic [XLEN-1:0] data_o
);

    logic [15:0] shifted;
    assign shifted = 16'(rdata_i >> {off_i, 3'b000});

    always_comb begin
        data_o = rdata_i;
        case (funct3_i)
            LB:      data_o = {{(XLEN-8){shifted[7]}}, shifted[7:0]};
            LH:      data_o = {{(XLEN-16){shifted[15]}}, shifted[15:0]};
            LBU:     data_o = {{(XLEN-8){1'b0}}, shifted[7:0]};
            LHU:     data_o = {{(XLEN-16){1'b0}}, shifted[15:0]};
            default: data_o = rdata_i;
        endcase
    end

endmodule

// File: rtl/load_store_unit.sv
// Memory-stage load/store unit: one bus transaction per request, store lane
// generation, load extension, error flagging. Optional bus timeout: LSU_TIMEOUT_EN.
module load_store_unit
    import lsu_pkg::*;
#(
    parameter int XLEN           = 32,
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     req_valid,
    input  logic                     req_we,
    input  logic [2:0]               req_funct3,
    input  logic [XLEN-1:0]          req_addr,
    input  logic [XLEN-1:0]          req_wdata,
    load_store_unit_if.master        mem,
    output logic                     lsu_busy,
    output logic                     resp_valid,
    output logic [XLEN-1:0]          resp_rdata,
    output logic                     resp_err,
    output logic [1:0]               err_cause
);

    lsu_state_e      state_q, state_d;
    logic            mem_req_q, mem_req_d;
    logic            mem_we_q, mem_we_d;
    logic [XLEN-1:0] mem_addr_q, mem_addr_d;
    logic [3:0]      mem_be_q, mem_be_d;
    logic [XLEN-1:0] mem_wdata_q, mem_wdata_d;
    logic [2:0]      funct3_q, funct3_d;
    logic [1:0]      off_q, off_d;
    logic [XLEN-1:0] resp_rdata_q, resp_rdata_d;
    logic            resp_err_q, resp_err_d;
    logic [1:0]      err_cause_q, err_cause_d;

    logic [3:0]      st_be;
    logic [XLEN-1:0] st_wdata;
    logic [XLEN-1:0] load_data;
    logic            tmo_hit;

    always_comb begin
        st_be    = 4'b1111;
        st_wdata = req_wdata;
        case (req_funct3[1:0])
            2'b00: begin
                st_be    = 4'b0001 << req_addr[1:0];
                st_wdata = {4{req_wdata[7:0]}};
            end
            2'b01: begin
                st_be    = req_addr[1] ? 4'b1100 : 4'b0011;
                st_wdata = {2{req_wdata[15:0]}};
            end
            default: ;
        endcase
    end

    lsu_load_align #(.XLEN(XLEN)) u_align (
        .funct3_i (funct3_q),
        .off_i    (off_q),
        .rdata_i  (mem.mem_rdata),
        .data_o   (load_data)
    );

`ifdef LSU_TIMEOUT_EN
    logic [7:0] tmo_cnt_q;

    // Zero everywhere outside BUSY, so it is already clear on entry to BUSY
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)                                 tmo_cnt_q <= '0;
        else if (state_q == BUSY && !mem.mem_ready) tmo_cnt_q <= tmo_cnt_q + 8'd1;
        else                                        tmo_cnt_q <= '0;
    end

    assign tmo_hit = (state_q == BUSY) && (tmo_cnt_q == 8'(TIMEOUT_CYCLES - 1));
`else
    // Timeout disabled: never fires for any legal TIMEOUT_CYCLES value
    assign tmo_hit = (TIMEOUT_CYCLES == 0);
`endif

    always_comb begin
        state_d      = state_q;
        mem_req_d    = mem_req_q;
        mem_we_d     = mem_we_q;
        mem_addr_d   = mem_addr_q;
        mem_be_d     = mem_be_q;
        mem_wdata_d  = mem_wdata_q;
        funct3_d     = funct3_q;
        off_d        = off_q;
        resp_rdata_d = resp_rdata_q;
        resp_err_d   = resp_err_q;
        err_cause_d  = err_cause_q;
        case (state_q)
            IDLE: begin
                if (req_valid) begin
                    if (!f3_legal(req_we, req_funct3) || f3_misaligned(req_funct3, req_addr[1:0])) begin
                        state_d      = RESP;
                        resp_rdata_d = '0;
                        resp_err_d   = 1'b1;
                        err_cause_d  = !f3_legal(req_we, req_funct3) ? ERR_ILLEGAL : ERR_MISALIGN;
                    end else begin
                        state_d     = BUSY;
                        mem_req_d   = 1'b1;
                        mem_we_d    = req_we;
                        mem_addr_d  = {req_addr[XLEN-1:2], 2'b00};
                        mem_be_d    = req_we ? st_be : 4'b1111;
                        mem_wdata_d = st_wdata;
                        funct3_d    = req_funct3;
                        off_d       = req_addr[1:0];
                    end
                end
            end
            BUSY: begin
                if (mem.mem_ready) begin
                    state_d      = RESP;
                    mem_req_d    = 1'b0;
                    resp_rdata_d = mem_we_q ? '0 : load_data;
                    resp_err_d   = 1'b0;
                    err_cause_d  = ERR_NONE;
                end else if (tmo_hit) begin
                    state_d      = RESP;
                    mem_req_d    = 1'b0;
                    resp_rdata_d = '0;
                    resp_err_d   = 1'b1;
                    err_cause_d  = ERR_TIMEOUT;
                end
            end
            RESP:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= IDLE;
            mem_req_q    <= 1'b0;
            mem_we_q     <= 1'b0;
            mem_addr_q   <= '0;
            mem_be_q     <= '0;
            mem_wdata_q  <= '0;
            funct3_q     <= '0;
            off_q        <= '0;
            resp_rdata_q <= '0;
            resp_err_q   <= 1'b0;
            err_cause_q  <= ERR_NONE;
        end else begin
            state_q      <= state_d;
            mem_req_q    <= mem_req_d;
            mem_we_q     <= mem_we_d;
            mem_addr_q   <= mem_addr_d;
            mem_be_q     <= mem_be_d;
            mem_wdata_q  <= mem_wdata_d;
            funct3_q     <= funct3_d;
            off_q        <= off_d;
            resp_rdata_q <= resp_rdata_d;
            resp_err_q   <= resp_err_d;
            err_cause_q  <= err_cause_d;
        end
    end

    assign mem.mem_req   = mem_req_q;
    assign mem.mem_we    = mem_we_q;
    assign mem.mem_addr  = mem_addr_q;
    assign mem.mem_be    = mem_be_q;
    assign mem.mem_wdata = mem_wdata_q;

    assign lsu_busy   = (state_q == IDLE && req_valid) || (state_q == BUSY);
    assign resp_valid = (state_q == RESP);
    assign resp_rdata = resp_rdata_q;
    assign resp_err   = resp_err_q;
    assign err_cause  = err_cause_q;

endmodule

// File: tb/tb_load_store_unit.sv
// Scoreboard bench for load_store_unit: expected responses are queued when a
// request is driven and popped when resp_valid fires.
module tb_load_store_unit;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        req_valid = 1'b0;
    logic        req_we = 1'b0;
    logic [2:0]  req_funct3 = 3'b000;
    logic [31:0] req_addr = '0;
    logic [31:0] req_wdata = '0;
    logic        lsu_busy;
    logic        resp_valid;
    logic [31:0] resp_rdata;
    logic        resp_err;
    logic [1:0]  err_cause;

    load_store_unit_if #(.XLEN(32)) mem_bus ();

    load_store_unit #(.XLEN(32), .TIMEOUT_CYCLES(4)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .req_valid  (req_valid),
        .req_we     (req_we),
        .req_funct3 (req_funct3),
        .req_addr   (req_addr),
        .req_wdata  (req_wdata),
        .mem        (mem_bus),
        .lsu_busy   (lsu_busy),
        .resp_valid (resp_valid),
        .resp_rdata (resp_rdata),
        .resp_err   (resp_err),
        .err_cause  (err_cause)
    );

    always #5 clk = ~clk;

    typedef struct {
        string       tag;
        logic [31:0] rdata;
        logic        err;
        logic [1:0]  cause;
    } exp_t;

    exp_t sb_q[$];
    int   n_checks = 0;
    int   n_fail   = 0;
    int   n_starts = 0;
    logic mreq_prev = 1'b0;

    task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s actual=0x%08h required=0x%08h", tag, act, exp);
        end
    endtask

    // Response monitor: pops the scoreboard on every completion pulse
    always @(negedge clk) begin
        if (rst_n && mem_bus.mem_req && !mreq_prev) n_starts++;
        mreq_prev = mem_bus.mem_req;
        if (rst_n && resp_valid) begin
            if (sb_q.size() == 0) begin
                check_eq("unexpected_resp", 32'd1, 32'd0);
            end else begin
                exp_t e;
                e = sb_q.pop_front();
                check_eq({e.tag, ":rdata"}, resp_rdata, e.rdata);
                check_eq({e.tag, ":err"},   {31'd0, resp_err}, {31'd0, e.err});
                check_eq({e.tag, ":cause"}, {30'd0, err_cause}, {30'd0, e.cause});
                $display("TXN %s rdata=0x%08h err=%0b cause=%0b", e.tag, resp_rdata, resp_err, err_cause);
            end
        end
    end

    // k: mem_ready is given in cycle N+k where N is the accepting edge
    task automatic run_txn(input string tag, input logic we, input logic [2:0] f3,
                           input logic [31:0] addr, input logic [31:0] wd, input int k,
                           input logic [31:0] rd, input logic [3:0] ebe, input logic [31:0] ewd,
                           input logic [31:0] erd, input logic [1:0] ecause, input bit keep);
        exp_t e;
        logic [31:0] waddr;
        bit bus;
        bus   = (ecause == 2'b00);
        waddr = {addr[31:2], 2'b00};
        @(posedge clk); #1;
        req_valid = 1'b1; req_we = we; req_funct3 = f3; req_addr = addr; req_wdata = wd;
        e.tag = tag; e.rdata = erd; e.err = (ecause != 2'b00); e.cause = ecause;
        sb_q.push_back(e);
        @(negedge clk);
        check_eq({tag, ":busy_idle"}, {31'd0, lsu_busy}, 32'd1);
        check_eq({tag, ":req_early"}, {31'd0, mem_bus.mem_req}, 32'd0);
        @(negedge clk);
        if (bus) begin
            check_eq({tag, ":addr"}, mem_bus.mem_addr, waddr);
            check_eq({tag, ":be"},   {28'd0, mem_bus.mem_be}, {28'd0, ebe});
            check_eq({tag, ":we"},   {31'd0, mem_bus.mem_we}, {31'd0, we});
            if (we) check_eq({tag, ":wdata"}, mem_bus.mem_wdata, ewd);
            for (int c = 1; c <= k; c++) begin
                check_eq({tag, ":req_hold"}, {31'd0, mem_bus.mem_req}, 32'd1);
                check_eq({tag, ":busy"},     {31'd0, lsu_busy}, 32'd1);
                check_eq({tag, ":resp_early"}, {31'd0, resp_valid}, 32'd0);
                if (c == k) begin
                    mem_bus.mem_ready = 1'b1;
                    mem_bus.mem_rdata = rd;
                end
                @(negedge clk);
            end
            mem_bus.mem_ready = 1'b0;
            mem_bus.mem_rdata = 32'h5A5A_5A5A;
        end
        check_eq({tag, ":resp_lat"}, {31'd0, resp_valid}, 32'd1);
        check_eq({tag, ":req_done"}, {31'd0, mem_bus.mem_req}, 32'd0);
        check_eq({tag, ":busy_resp"}, {31'd0, lsu_busy}, 32'd0);
        if (!keep) req_valid = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int s0;
        mem_bus.mem_ready = 1'b0;
        mem_bus.mem_rdata = 32'h5A5A_5A5A;
        #12;
        check_eq("rst:mem_req",    {31'd0, mem_bus.mem_req}, 32'd0);
        check_eq("rst:mem_we",     {31'd0, mem_bus.mem_we}, 32'd0);
        check_eq("rst:mem_addr",   mem_bus.mem_addr, 32'd0);
        check_eq("rst:mem_be",     {28'd0, mem_bus.mem_be}, 32'd0);
        check_eq("rst:mem_wdata",  mem_bus.mem_wdata, 32'd0);
        check_eq("rst:resp_valid", {31'd0, resp_valid}, 32'd0);
        check_eq("rst:resp_rdata", resp_rdata, 32'd0);
        check_eq("rst:resp_err",   {31'd0, resp_err}, 32'd0);
        check_eq("rst:err_cause",  {30'd0, err_cause}, 32'd0);
        check_eq("rst:busy",       {31'd0, lsu_busy}, 32'd0);
        @(negedge clk); rst_n = 1'b1;

        //      tag      we    f3      addr          wdata         k  mem_rdata     be       wdata_exp     resp_rdata    cause  keep
        run_txn("sw",    1'b1, 3'b010, 32'h0000_0100, 32'hDEAD_BEEF, 2, 32'hFFFF_FFFF, 4'b1111, 32'hDEAD_BEEF, 32'h0,        2'b00, 0);
        run_txn("sb",    1'b1, 3'b000, 32'h0000_0103, 32'h0000_00A5, 1, 32'hFFFF_FFFF, 4'b1000, 32'hA5A5_A5A5, 32'h0,        2'b00, 0);
        run_txn("sh",    1'b1, 3'b001, 32'h0000_0102, 32'h1234_ABCD, 3, 32'hFFFF_FFFF, 4'b1100, 32'hABCD_ABCD, 32'h0,        2'b00, 0);
        run_txn("sb0",   1'b1, 3'b000, 32'h0000_0101, 32'h0000_003C, 1, 32'hFFFF_FFFF, 4'b0010, 32'h3C3C_3C3C, 32'h0,        2'b00, 0);
        run_txn("lb",    1'b0, 3'b000, 32'h0000_0102, 32'h0,         2, 32'h80FF_7F01, 4'b1111, 32'h0,         32'hFFFF_FFFF, 2'b00, 0);
        run_txn("lbu",   1'b0, 3'b100, 32'h0000_0102, 32'h0,         1, 32'h80FF_7F01, 4'b1111, 32'h0,         32'h0000_00FF, 2'b00, 0);
        run_txn("lh",    1'b0, 3'b001, 32'h0000_0102, 32'h0,         1, 32'h80FF_7F01, 4'b1111, 32'h0,         32'hFFFF_80FF, 2'b00, 0);
        run_txn("lhu",   1'b0, 3'b101, 32'h0000_0102, 32'h0,         2, 32'h80FF_7F01, 4'b1111, 32'h0,         32'h0000_80FF, 2'b00, 0);
        run_txn("lb1",   1'b0, 3'b000, 32'h0000_0101, 32'h0,         1, 32'h80FF_7F01, 4'b1111, 32'h0,         32'h0000_007F, 2'b00, 0);
        run_txn("lw",    1'b0, 3'b010, 32'h0000_0104, 32'h0,         1, 32'h1234_5678, 4'b1111, 32'h0,         32'h1234_5678, 2'b00, 0);
        run_txn("lw_mis", 1'b0, 3'b010, 32'h0000_0101, 32'h0,        0, 32'h0,         4'b0000, 32'h0,         32'h0,         2'b01, 0);
        run_txn("sh_mis", 1'b1, 3'b001, 32'h0000_0103, 32'h0,        0, 32'h0,         4'b0000, 32'h0,         32'h0,         2'b01, 0);
        run_txn("ld011", 1'b0, 3'b011, 32'h0000_0100, 32'h0,         0, 32'h0,         4'b0000, 32'h0,         32'h0,         2'b10, 0);
        run_txn("st100", 1'b1, 3'b100, 32'h0000_0100, 32'h0,         0, 32'h0,         4'b0000, 32'h0,         32'h0,         2'b10, 0);
        run_txn("ill_pri", 1'b0, 3'b011, 32'h0000_0101, 32'h0,       0, 32'h0,         4'b0000, 32'h0,         32'h0,         2'b10, 0);

        // req_valid held through RESP: each instruction is one transaction
        s0 = n_starts;
        run_txn("b2b_a", 1'b0, 3'b010, 32'h0000_0200, 32'h0, 1, 32'hCAFE_0001, 4'b1111, 32'h0, 32'hCAFE_0001, 2'b00, 1);
        run_txn("b2b_b", 1'b0, 3'b010, 32'h0000_0200, 32'h0, 1, 32'hCAFE_0002, 4'b1111, 32'h0, 32'hCAFE_0002, 2'b00, 0);
        @(negedge clk);
        @(negedge clk);
        check_eq("b2b:starts", n_starts - s0, 32'd2);

        // mem_ready while idle is ignored
        mem_bus.mem_ready = 1'b1;
        @(negedge clk);
        check_eq("stray_ready:resp", {31'd0, resp_valid}, 32'd0);
        check_eq("stray_ready:req",  {31'd0, mem_bus.mem_req}, 32'd0);
        mem_bus.mem_ready = 1'b0;

`ifdef LSU_TIMEOUT_EN
        begin
            exp_t e;
            int cyc;
            @(posedge clk); #1;
            req_valid = 1'b1; req_we = 1'b0; req_funct3 = 3'b010; req_addr = 32'h0000_0300;
            e.tag = "timeout"; e.rdata = 32'h0; e.err = 1'b1; e.cause = 2'b11;
            sb_q.push_back(e);
            @(negedge clk);
            @(negedge clk);
            cyc = 0;
            while (mem_bus.mem_req && cyc < 20) begin
                cyc++;
                @(negedge clk);
            end
            check_eq("timeout:req_cycles", cyc, 32'd4);
            check_eq("timeout:resp", {31'd0, resp_valid}, 32'd1);
            req_valid = 1'b0;
        end
`endif

        // Asynchronous reset while BUSY
        @(posedge clk); #1;
        req_valid = 1'b1; req_we = 1'b1; req_funct3 = 3'b010; req_addr = 32'h0000_0400; req_wdata = 32'h1111_2222;
        @(negedge clk);
        @(negedge clk);
        check_eq("arst:req_before", {31'd0, mem_bus.mem_req}, 32'd1);
        #1;
        rst_n = 1'b0;
        req_valid = 1'b0;
        #1;
        check_eq("arst:req_drop", {31'd0, mem_bus.mem_req}, 32'd0);
        check_eq("arst:idle",     {31'd0, lsu_busy}, 32'd0);
        check_eq("arst:addr",     mem_bus.mem_addr, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        check_eq("arst:no_resp", {31'd0, resp_valid}, 32'd0);

        check_eq("sb_empty", sb_q.size(), 32'd0);
        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
